oam_dma_arbiter: RTL and testbench



---
 rtl/oam_dma_arbiter.sv | 120 ++++++++++++
 tb/tb_oam_dma_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: passes CPU bus accesses through. A CPU write to
// TRIGGER_ADDR makes it take the bus, stall the CPU and copy 256 bytes
// from page {data,8'h00} to OAM_DATA_ADDR with NES cycle timing.
// Ports:
//   clk, rst_n          - clock (CPU rate), async active-low reset
//   cpu_addr/read/write - CPU memory-address stage request
//   cpu_wdata           - CPU write data
//   bus_rdata           - bus read data, valid in the same cycle as bus_read
//   bus_addr/read/write - system bus request
//   bus_wdata           - system bus write data
//   cpu_stall           - holds the CPU while the DMA owns the bus
//   dma_active          - high whenever the engine is not idle
module oam_dma_arbiter #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_read,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    output logic        cpu_stall,
    output logic        dma_active
);

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] IDLE  = 3'd0;
    localparam logic [ST_W-1:0] DUMMY = 3'd1;
    localparam logic [ST_W-1:0] ALIGN = 3'd2;
    localparam logic [ST_W-1:0] READ  = 3'd3;
    localparam logic [ST_W-1:0] WRITE = 3'd4;

    logic [ST_W-1:0] state, state_nxt;
    logic [7:0]      page, page_nxt;
    logic [7:0]      idx, idx_nxt;
    logic [7:0]      dma_data, dma_data_nxt;
    logic            cyc_par;

    // State and datapath registers; cyc_par tracks CPU cycle parity forever
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            dma_data <= 8'h00;
            cyc_par  <= 1'b0;
        end else begin
            state    <= state_nxt;
            page     <= page_nxt;
            idx      <= idx_nxt;
            dma_data <= dma_data_nxt;
            cyc_par  <= ~cyc_par;
        end
    end

    // Next-state and bus muxing; outputs depend only on state and registers
    // (plus the CPU request while idle, which is a pure passthrough)
    always_comb begin
        state_nxt    = state;
        page_nxt     = page;
        idx_nxt      = idx;
        dma_data_nxt = dma_data;
        bus_addr     = 16'h0000;
        bus_read     = 1'b0;
        bus_write    = 1'b0;
        bus_wdata    = 8'h00;
        cpu_stall    = 1'b1;

        case (state)
            IDLE: begin
                bus_addr  = cpu_addr;
                bus_read  = cpu_read;
                bus_write = cpu_write;
                bus_wdata = cpu_wdata;
                cpu_stall = 1'b0;
                // The trigger write itself still reaches the bus
                if (cpu_write && (cpu_addr == TRIGGER_ADDR)) begin
                    page_nxt  = cpu_wdata;
                    idx_nxt   = 8'h00;
                    state_nxt = DUMMY;
                end
            end
            DUMMY: begin
                // Halting on an odd cycle costs one extra alignment cycle
                state_nxt = cyc_par ? ALIGN : READ;
            end
            ALIGN: begin
                state_nxt = READ;
            end
            READ: begin
                bus_addr     = {page, idx};
                bus_read     = 1'b1;
                dma_data_nxt = bus_rdata;
                state_nxt    = WRITE;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_write = 1'b1;
                bus_wdata = dma_data;
                // 8-bit increment keeps the source address inside the page
                idx_nxt   = idx + 8'd1;
                state_nxt = (idx == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_nxt = IDLE;
                cpu_stall = 1'b0;
            end
        endcase
    end

    assign dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: a byte-array memory answers bus
// reads, and each DMA is checked against the expected copy sequence and
// stall length derived from the cycle parity counted by the bench.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  bus_rdata;
    logic [15:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic        cpu_stall;
    logic        dma_active;

    logic [7:0]  mem [65536];
    int          edges;
    int          errors;
    int          checks;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .bus_rdata  (bus_rdata),
        .bus_addr   (bus_addr),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .bus_wdata  (bus_wdata),
        .cpu_stall  (cpu_stall),
        .dma_active (dma_active)
    );

    assign bus_rdata = mem[bus_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CPU cycle count since reset; its low bit is the expected cycle parity
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_passthrough(input string tag);
        check({tag, ".addr"},  32'(bus_addr),  32'(cpu_addr));
        check({tag, ".rd"},    32'(bus_read),  32'(cpu_read));
        check({tag, ".wr"},    32'(bus_write), 32'(cpu_write));
        check({tag, ".wdata"}, 32'(bus_wdata), 32'(cpu_wdata));
        check({tag, ".stall"}, 32'(cpu_stall), 32'd0);
    endtask

    // Entered just after a negedge with the DUT idle; returns just after the
    // negedge of the first idle cycle following the transfer. want_par < 0
    // means trigger immediately regardless of parity.
    task automatic run_dma(input logic [7:0] page, input int want_par);
        int stall_n;
        int rd_n;
        int wr_n;
        int par;
        int budget;
        bit done;
        if (want_par >= 0) begin
            while (((edges + 1) % 2) != want_par) @(negedge clk);
        end
        cpu_addr  = 16'h4014;
        cpu_read  = 1'b0;
        cpu_write = 1'b1;
        cpu_wdata = page;
        #1;
        check_passthrough("trigger");
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
        cpu_addr  = 16'(16'h0400 + $urandom_range(0, 255));
        cpu_wdata = 8'($urandom);
        stall_n = 0; rd_n = 0; wr_n = 0; par = -1; budget = 0; done = 0;
        while (!done && budget < 600) begin
            @(negedge clk);
            budget++;
            if (!cpu_stall) begin
                done = 1;
            end else begin
                if (stall_n == 0) begin
                    par = edges % 2;
                    check("dummy_idle", 32'({bus_read, bus_write, bus_addr}), 32'd0);
                end
                stall_n++;
                check("active", 32'(dma_active), 32'd1);
                if (bus_read) begin
                    check("rd_addr", 32'(bus_addr), 32'({page, 8'(rd_n)}));
                    rd_n++;
                end
                if (bus_write) begin
                    check("wr_addr", 32'(bus_addr), 32'h2004);
                    check("wr_data", 32'(bus_wdata), 32'(mem[{page, 8'(wr_n)}]));
                    wr_n++;
                end
            end
        end
        check("dma_done", 32'(done), 32'd1);
        check("reads",  32'(rd_n), 32'd256);
        check("writes", 32'(wr_n), 32'd256);
        check("stall_len", 32'(stall_n), 32'(513 + par));
        if (want_par >= 0) check("parity", 32'(par), 32'(want_par));
        check("end_active", 32'(dma_active), 32'd0);
        check_passthrough("end_idle");
    endtask

    initial begin
        int bad;
        errors = 0;
        checks = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
            mem[16'h0300 + i] = 8'(i) ^ 8'h3C;
        end
        rst_n     = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_stall",  32'(cpu_stall),  32'd0);
        check("rst_active", 32'(dma_active), 32'd0);
        check("rst_xfree",  32'($isunknown({bus_addr, bus_read, bus_write, bus_wdata})), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Passthrough, fixed then random non-trigger accesses
        cpu_addr = 16'h0300; cpu_write = 1'b1; cpu_wdata = 8'h5A;
        #1;
        check_passthrough("pass_fixed");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cpu_addr  = 16'($urandom);
            if (cpu_addr == 16'h4014) cpu_addr = 16'h4013;
            cpu_read  = 1'($urandom);
            cpu_write = 1'($urandom);
            cpu_wdata = 8'($urandom);
            #1;
            check_passthrough("pass_rand");
        end
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0;

        run_dma(8'h02, 0);
        run_dma(8'h02, 1);

        // Non-triggers
        cpu_addr = 16'h4014; cpu_read = 1'b1; cpu_write = 1'b0;
        #1;
        check_passthrough("read_4014");
        @(negedge clk);
        cpu_addr = 16'h4015; cpu_read = 1'b0; cpu_write = 1'b1; cpu_wdata = 8'h02;
        check("after_read_4014", 32'(cpu_stall), 32'd0);
        #1;
        check_passthrough("write_4015");
        @(negedge clk);
        cpu_write = 1'b0;
        check("after_write_4015", 32'(cpu_stall), 32'd0);

        run_dma(8'hFF, -1);

        // Back-to-back: second trigger in the first idle cycle
        run_dma(8'h02, 0);
        run_dma(8'h03, -1);

        // Reset in the middle of a transfer
        @(negedge clk);
        cpu_addr = 16'h4014; cpu_write = 1'b1; cpu_wdata = 8'h02;
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
        bad = 1;
        for (int c = 0; c < 600 && bad == 1; c++) begin
            @(negedge clk);
            if (bus_read && bus_addr == 16'h0264) bad = 0;
        end
        check("reached_idx100", 32'(bad), 32'd0);
        #1;
        cpu_addr = 16'h1234; cpu_read = 1'b1; cpu_wdata = 8'h77;
        rst_n = 1'b0;
        #1;
        check("rst_mid_active", 32'(dma_active), 32'd0);
        check_passthrough("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        cpu_read = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cpu_stall || (bus_write && bus_addr == 16'h2004)) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
